// File: rtl/muller_c_proj.sv
// Clocked Muller C-element network: six synchronized pads pair into three
// 2-input C-elements, merged by a 3-input C-element with a transition counter.
module muller_c_proj #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [5:0] io_in,
    output logic [7:0] io_out,
    output logic [7:0] io_oeb
);

    logic [5:0]       sync_q [SYNC_STAGES];
    logic [5:0]       s;
    logic [2:0]       c_q;
    logic [2:0]       c_d;
    logic             cm_q;
    logic             cm_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       cnt_out;

    // A C-element follows its inputs when they agree and holds otherwise.
    function automatic logic c_elem2(input logic a, input logic b, input logic q);
        return (a == b) ? a : q;
    endfunction

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        c_d[0] = c_elem2(s[0], s[1], c_q[0]);
        c_d[1] = c_elem2(s[2], s[3], c_q[1]);
        c_d[2] = c_elem2(s[4], s[5], c_q[2]);
    end

    always_comb begin
        cm_d = cm_q;
        if (&c_q)
            cm_d = 1'b1;
        else if (~|c_q)
            cm_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            c_q   <= '0;
            cm_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            c_q  <= c_d;
            cm_q <= cm_d;
            if (cm_d != cm_q)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    generate
        if (CNT_W >= 4) begin : g_cnt_wide
            assign cnt_out = cnt_q[3:0];
        end else begin : g_cnt_narrow
            assign cnt_out = {{(4-CNT_W){1'b0}}, cnt_q};
        end
    endgenerate

    assign io_out = {cnt_out, cm_q, c_q};
    assign io_oeb = '0;

endmodule

// File: tb/tb_muller_c_proj.sv
// Directed bench for muller_c_proj: a pad-history model checked every cycle,
// plus literal io_out expectations at key points of each scenario.
module tb_muller_c_proj;

    localparam int SYNC = 2;
    localparam int CW   = 4;

    logic       clk;
    logic       rst;
    logic [5:0] io_in;
    logic [7:0] io_out;
    logic [7:0] io_oeb;

    int nvec = 0;
    int nerr = 0;

    muller_c_proj #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the value a pair element sees at an edge is the pad value
    // sampled SYNC edges earlier (zeros since reset).
    logic [5:0] hist [$];
    logic [2:0] m_c;
    logic       m_cm;
    int         m_cnt;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        logic [5:0] sb;
        logic [1:0] pr;
        logic [2:0] nc;
        logic       ncm;
        if (rst) begin
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back(6'd0);
            m_c = '0; m_cm = 1'b0; m_cnt = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            sb = hist[hist.size() - SYNC];
            hist.push_back(io_in);
            if (hist.size() > SYNC + 2) void'(hist.pop_front());
            nc = m_c;
            for (int k = 0; k < 3; k++) begin
                pr = 2'(sb >> (2 * k));
                if ($countones(pr) == 2) nc[k] = 1'b1;
                else if ($countones(pr) == 0) nc[k] = 1'b0;
            end
            ncm = m_cm;
            if ($countones(m_c) == 3) ncm = 1'b1;
            else if ($countones(m_c) == 0) ncm = 1'b0;
            if (ncm != m_cm) m_cnt = (m_cnt + 1) % (1 << CW);
            m_c = nc; m_cm = ncm;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            nvec++;
            if (io_out !== {4'(m_cnt), m_cm, m_c}) begin
                nerr++;
                $display("FAIL model_io_out t=%0t got=%02h exp=%02h", $time, io_out, {4'(m_cnt), m_cm, m_c});
            end
            nvec++;
            if (io_oeb !== 8'h00) begin
                nerr++;
                $display("FAIL io_oeb t=%0t got=%02h exp=00", $time, io_oeb);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        nvec++;
        if (io_out !== exp) begin
            nerr++;
            $display("FAIL %s got=%02h exp=%02h", name, io_out, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        io_in = 6'h3F;
        tick(1); check("reset_1", 8'h00);
        tick(1); check("reset_2", 8'h00);
        rst   = 1'b0;
        io_in = 6'b111011;
        tick(1); check("post_release", 8'h00);
        tick(2); check("pair_hold_c1", 8'h05);
        tick(1); check("merge_hold_mixed", 8'h05);

        io_in = 6'h3F;
        tick(3); check("pairs_all_set", 8'h07);
        tick(1); check("merge_set", 8'h1F);

        io_in = 6'b010101;
        tick(5); check("partial_clear_holds", 8'h1F);

        io_in = 6'h00;
        tick(3); check("pairs_all_clear", 8'h18);
        tick(1); check("merge_clear", 8'h20);

        rst = 1'b1; tick(1); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            io_in = (i % 2 == 0) ? 6'h3F : 6'h00;
            tick(5);
            if (i == 14) check("count_15", 8'hFF);
        end
        check("count_wrap", 8'h00);

        rst = 1'b1; tick(1); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            io_in = (i % 2 == 0) ? 6'h3F : 6'h00;
            tick(5);
        end
        check("count_5_set", 8'h5F);
        rst = 1'b1;
        tick(1); check("mid_reset", 8'h00);
        rst = 1'b0;
        tick(3); check("after_reset_pairs", 8'h07);
        tick(1); check("after_reset_merge", 8'h1F);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/muller_c_proj.md
Name: muller_c_proj

Overview:
- Clocked, synthesizable Muller C-element network for the user-project IO area.
- Six pad inputs are synchronized, then paired into three 2-input C-elements.
- A 3-input C-element merges the three pair outputs.
- Element states plus a 4-bit transition counter of the merged output drive the IO pads; the block is the formal/cover target for C-element hold behaviour.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages per io_in bit (legal ≥1).
- CNT_W, 4, width of the merged-output transition counter.

Ports:
- wb_clk_i  input  1  single system clock; all state updates on its rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- io_in  input  6  asynchronous pad inputs; pairs {1:0}, {3:2}, {5:4} feed C-elements c0, c1, c2.
- io_out  output  8  [0]=c0, [1]=c1, [2]=c2, [3]=cm (merged), [7:4]=transition count.
- io_oeb  output  8  output-enable-bar; constant 8'h00 (all pads driven).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (wb_clk_i / wb_rst_i).
- Reset: all synchronizer flops, c0, c1, c2, cm and the counter clear to 0 on a rising edge with wb_rst_i=1; io_out = 8'h00 from the next edge.
- Reset wins over every other update in the same cycle. Reset mid-operation discards in-flight synchronizer contents.
- Synchronizer: each io_in bit passes through SYNC_STAGES flops; s[5:0] is the last-stage value.
- Pair element rule, evaluated each edge for k in 0..2, with a=s[2k], b=s[2k+1]:
  - a=b=1: ck <= 1.
  - a=b=0: ck <= 0.
  - a≠b: ck holds.
- Merged element cm, computed from registered c0..c2:
  - all 1: cm <= 1.
  - all 0: cm <= 0.
  - mixed: cm holds.
- Latency: io_in change → s after SYNC_STAGES edges → ck one edge later → cm one edge after ck. Total SYNC_STAGES+2 edges from pad to cm (4 with defaults).
- Counter: increments by 1 on every edge where the next cm differs from the current cm. Wraps modulo 2^CNT_W (15→0); no saturation.
- io_out[7:4] carries the counter's low 4 bits. If CNT_W>4, upper bits are internal only; if CNT_W<4, zero-extend.
- No combinational path from io_in to io_out; all outputs are registered.
- Simultaneous change of both inputs of a pair in one cycle is legal: the element evaluates the new synchronized values directly.
- Glitches shorter than one clock period may be missed; this is acceptable by design.

Test Plan:
- Reset check: hold wb_rst_i=1 for 2 cycles with io_in=6'b111111 → io_out=8'h00, io_oeb=8'h00 throughout and 1 cycle after release.
- Hold on mismatch: after reset apply io_in=6'b111011 → after 3 edges io_out[2:0]=3'b101 (c1 holds 0). After 4 edges cm=0 (mixed, holds); count=0.
- Full set: from the previous state apply io_in=6'b111111 → c1=1 after 3 edges, cm=1 one edge later, io_out=8'h1F (count=1, bits[3:0]=4'hF).
- Partial clear holds: apply io_in=6'b010101 → c0..c2 hold 1, cm stays 1, io_out unchanged at 8'h1F. Then apply 6'b000000 → c0..c2=0, then cm=0; io_out=8'h20 (count=2).
- Wrap-around: toggle io_in between 6'h3F and 6'h00 for 16 cm transitions → count returns to 0; io_out[7:4]=0 after the 16th transition.
- Mid-operation reset: assert wb_rst_i while cm=1 with count=5 and io_in=6'h3F → next edge io_out=8'h00. After release, cm reaches 1 again after SYNC_STAGES+2 edges and count=1.
